// File: rtl/bloque_botones_pkg.sv
// -----------------------------------------------------------------------------
// bloque_botones_pkg
// Shared definitions for the push-button front end of the date/time editor:
// FSM state type, button bit positions and default timing parameters.
// Optional feature macro: AUTOREPEAT_EN (adds the REPITE state).
// -----------------------------------------------------------------------------
package bloque_botones_pkg;

  localparam int N_BOT = 4;

  // Bit positions inside IN_botones / OUT_bot_fecha.
  localparam int ARRIBA = 0;
  localparam int ABAJO  = 1;
  localparam int IZQ    = 2;
  localparam int DER    = 3;

  localparam int DEB_CICLOS_DEF  = 16;
  localparam int RETARDO_REP_DEF = 50;
  localparam int PERIODO_REP_DEF = 10;

`ifdef AUTOREPEAT_EN
  typedef enum logic [1:0] {REPOSO, SOSTENIDO, REPITE, ESPERA_LIBRE} estado_t;
`else
  typedef enum logic [1:0] {REPOSO, SOSTENIDO, ESPERA_LIBRE} estado_t;
`endif

  // True when exactly one button is pressed.
  function automatic logic es_one_hot(input logic [N_BOT-1:0] v);
    return (v != '0) && ((v & (v - N_BOT'(1))) == '0);
  endfunction

endpackage

// File: rtl/bloque_botones_if.sv
// -----------------------------------------------------------------------------
// bloque_botones_if
// Groups the button block's functional signals.
//   IN_botones    raw push-buttons (bit0 up, bit1 down, bit2 left, bit3 right)
//   enable_bot    1 = command pulses allowed (edit mode)
//   OUT_bot_fecha one-hot, one-cycle command pulses
//   bot_activo    1 while any debounced button is pressed
// master: the side driving buttons; slave: bloque_botones.
// -----------------------------------------------------------------------------
interface bloque_botones_if;
  import bloque_botones_pkg::*;

  logic [N_BOT-1:0] IN_botones;
  logic             enable_bot;
  logic [N_BOT-1:0] OUT_bot_fecha;
  logic             bot_activo;

  modport master (output IN_botones, enable_bot, input OUT_bot_fecha, bot_activo);
  modport slave  (input IN_botones, enable_bot, output OUT_bot_fecha, bot_activo);
endinterface

// File: rtl/bloque_botones_antirrebote.sv
// -----------------------------------------------------------------------------
// antirrebote
// One button: 2-flop synchronizer followed by a debounce counter. The level
// output only changes after the synchronized input has disagreed with it for
// DEB_CICLOS cycles and still disagrees on the following cycle.
//   reloj, resetM (sync, active-high), boton_raw (async), nivel (debounced)
// -----------------------------------------------------------------------------
module antirrebote
  import bloque_botones_pkg::*;
#(
  parameter int DEB_CICLOS = DEB_CICLOS_DEF
) (
  input  logic reloj,
  input  logic resetM,
  input  logic boton_raw,
  output logic nivel
);

  localparam int CW = $clog2(DEB_CICLOS + 1);

  logic          sinc1, sinc2;
  logic [CW-1:0] cuenta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; sinc1/sinc2 must stay a plain flop pair with no logic
  // between them, otherwise the synchronizer loses its metastability margin.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      sinc1  <= 1'b0;
      sinc2  <= 1'b0;
      cuenta <= '0;
      nivel  <= 1'b0;
    end else begin
      sinc1 <= boton_raw;
      sinc2 <= sinc1;
      if (sinc2 == nivel) begin
        cuenta <= '0;                       // any agreement restarts the run
      end else if (cuenta == CW'(DEB_CICLOS)) begin
        nivel  <= sinc2;                    // run complete: accept new level
        cuenta <= '0;
      end else begin
        cuenta <= cuenta + CW'(1);          // tops out at DEB_CICLOS, never wraps
      end
    end
  end

endmodule

// File: rtl/bloque_botones.sv
// -----------------------------------------------------------------------------
// bloque_botones
// Debounces four push-buttons and turns a single clean press into a one-cycle
// one-hot command pulse for the date/time edit block. Chords, presses while
// disabled, and changes of button while held are ignored until full release.
//   reloj   system clock (rising edge)
//   resetM  synchronous active-high reset
//   bus     bloque_botones_if.slave (IN_botones, enable_bot, OUT_bot_fecha,
//           bot_activo)
// Optional macro AUTOREPEAT_EN: a held button repeats after RETARDO_REP cycles
// and then every PERIODO_REP cycles.
// -----------------------------------------------------------------------------
module bloque_botones
  import bloque_botones_pkg::*;
#(
  parameter int DEB_CICLOS  = DEB_CICLOS_DEF,
  parameter int RETARDO_REP = RETARDO_REP_DEF,
  parameter int PERIODO_REP = PERIODO_REP_DEF
) (
  input  logic            reloj,
  input  logic            resetM,
  bloque_botones_if.slave bus
);

  if (DEB_CICLOS < 1 || RETARDO_REP < 1 || PERIODO_REP < 1) begin : g_param_check
    $error("bloque_botones: timing parameters must be >= 1");
  end

  logic [N_BOT-1:0] db;

  for (genvar i = 0; i < N_BOT; i++) begin : g_bot
    antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_antirrebote (
      .reloj     (reloj),
      .resetM    (resetM),
      .boton_raw (bus.IN_botones[i]),
      .nivel     (db[i])
    );
  end

  estado_t          estado, estado_sig;
  logic [N_BOT-1:0] retenido, retenido_sig;   // button that produced the pulse
  logic [N_BOT-1:0] pulso;
  logic [N_BOT-1:0] out_q;
  logic             activo_q;

`ifdef AUTOREPEAT_EN
  localparam int TMAX = (RETARDO_REP > PERIODO_REP) ? RETARDO_REP : PERIODO_REP;
  localparam int TW   = $clog2(TMAX + 1);
  logic [TW-1:0] temp, temp_sig;
`endif

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    estado_sig   = estado;
    retenido_sig = retenido;
    pulso        = '0;
`ifdef AUTOREPEAT_EN
    temp_sig     = temp;
`endif
    unique case (estado)
      REPOSO: begin
        if (db != '0) begin
          if (es_one_hot(db) && bus.enable_bot) begin
            pulso        = db;
            retenido_sig = db;
            estado_sig   = SOSTENIDO;
`ifdef AUTOREPEAT_EN
            temp_sig     = '0;
`endif
          end else begin
            estado_sig = ESPERA_LIBRE;
          end
        end
      end
      SOSTENIDO: begin
        if (db == '0) begin
          estado_sig = REPOSO;
        end else if (db != retenido || !bus.enable_bot) begin
          estado_sig = ESPERA_LIBRE;
`ifdef AUTOREPEAT_EN
        end else if (temp == TW'(RETARDO_REP)) begin
          pulso      = db;
          estado_sig = REPITE;
          temp_sig   = '0;
        end else begin
          temp_sig = temp + TW'(1);
`endif
        end
      end
`ifdef AUTOREPEAT_EN
      REPITE: begin
        if (db == '0) begin
          estado_sig = REPOSO;
        end else if (db != retenido || !bus.enable_bot) begin
          estado_sig = ESPERA_LIBRE;
        end else if (temp == TW'(PERIODO_REP - 1)) begin
          pulso    = db;
          temp_sig = '0;
        end else begin
          temp_sig = temp + TW'(1);
        end
      end
`endif
      ESPERA_LIBRE: begin
        if (db == '0) estado_sig = REPOSO;
      end
      default: estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge reloj) begin
    if (resetM) begin
      estado   <= REPOSO;
      retenido <= '0;
      out_q    <= '0;
      activo_q <= 1'b0;
`ifdef AUTOREPEAT_EN
      temp     <= '0;
`endif
    end else begin
      estado   <= estado_sig;
      retenido <= retenido_sig;
      out_q    <= pulso;
      activo_q <= |db;
`ifdef AUTOREPEAT_EN
      temp     <= temp_sig;
`endif
    end
  end

  assign bus.OUT_bot_fecha = out_q;
  assign bus.bot_activo    = activo_q;

endmodule

// File: tb/tb_bloque_botones.sv
// -----------------------------------------------------------------------------
// tb_bloque_botones
// Directed stimulus against bloque_botones with DEB_CICLOS=4, RETARDO_REP=20,
// PERIODO_REP=5. A behavioural model (raw-sample window debounce plus a
// press/hold/lockout description of the command rules) is compared with the
// DUT on every cycle; logged pulse times are pinned with literal expectations.
// -----------------------------------------------------------------------------
module tb_bloque_botones;

  localparam int DEB = 4;
  localparam int RET = 20;
  localparam int PER = 5;
  localparam int HL  = DEB + 2;

  logic reloj = 1'b0;
  logic resetM;
  bloque_botones_if bus ();

  bloque_botones #(.DEB_CICLOS(DEB), .RETARDO_REP(RET), .PERIODO_REP(PER)) dut (
    .reloj  (reloj),
    .resetM (resetM),
    .bus    (bus)
  );

  always #5 reloj = ~reloj;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;              // rising edges seen so far

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (edge %0d): got %0h, expected %0h", name, cyc, got, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] hist [HL];         // hist[k] = raw sample k+1 edges ago
  logic [3:0] m_db, m_out;
  logic       m_act;
  logic       locked;            // waiting for full release
  logic [3:0] holding;           // button whose press was accepted, 0 if none
  int         hold_n;
  logic       repeating;

  task automatic model_step();
    logic [3:0] d, nd;
    logic       all_diff;
    cyc++;
    if (resetM) begin
      for (int k = 0; k < HL; k++) hist[k] = '0;
      m_db = '0; m_out = '0; m_act = 1'b0;
      locked = 1'b0; holding = '0; hold_n = 0; repeating = 1'b0;
      return;
    end
    d     = m_db;
    m_act = |d;
    m_out = '0;
    if (locked) begin
      if (d == 0) locked = 1'b0;
    end else if (holding == 0) begin
      if (d != 0) begin
        if ($countones(d) == 1 && bus.enable_bot) begin
          m_out = d; holding = d; hold_n = 0; repeating = 1'b0;
        end else begin
          locked = 1'b1;
        end
      end
    end else begin
      if (d == 0) holding = '0;
      else if (d != holding || !bus.enable_bot) begin
        holding = '0; locked = 1'b1;
      end
`ifdef AUTOREPEAT_EN
      else begin
        hold_n++;
        if ((!repeating && hold_n == RET + 1) || (repeating && hold_n == PER)) begin
          m_out = d; repeating = 1'b1; hold_n = 0;
        end
      end
`endif
    end
    // A debounced bit flips once DEB+1 consecutive raw samples, seen through
    // the two-edge synchronizer delay, all disagree with it.
    nd = d;
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      for (int k = 1; k < HL; k++) if (hist[k][b] == d[b]) all_diff = 1'b0;
      if (all_diff) nd[b] = ~d[b];
    end
    m_db = nd;
    for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = bus.IN_botones;
  endtask

  initial forever begin
    @(posedge reloj);
    model_step();
  end

  // ---------------- per-cycle compare + pulse log ----------------
  int         pulse_cyc [$];
  logic [3:0] pulse_val [$];

  initial forever begin
    @(negedge reloj);
    if (cyc > 0) begin
      check("out_bot_fecha", 32'(bus.OUT_bot_fecha), 32'(m_out));
      check("bot_activo", 32'(bus.bot_activo), 32'(m_act));
      if (bus.OUT_bot_fecha != 0) begin
        pulse_cyc.push_back(cyc);
        pulse_val.push_back(bus.OUT_bot_fecha);
      end
    end
  end

  // Drive v/e so that exactly n rising edges sample it; first = first edge.
  task automatic apply(input logic [3:0] v, input logic e, input int n, output int first);
    @(negedge reloj);
    bus.IN_botones = v;
    bus.enable_bot = e;
    first = cyc + 1;
    repeat (n - 1) @(negedge reloj);
  endtask

  task automatic clear_log();
    pulse_cyc.delete();
    pulse_val.delete();
  endtask

  // ---------------- directed tests ----------------
  int t0, tl, tp, tr, dummy;

  initial begin
    bus.IN_botones = '0;
    bus.enable_bot = 1'b1;
    resetM = 1'b1;
    repeat (3) @(negedge reloj);
    check("reset_out", 32'(bus.OUT_bot_fecha), 32'h0);
    check("reset_act", 32'(bus.bot_activo), 32'h0);
    resetM = 1'b0;
    repeat (10) @(negedge reloj);

    // Clean press of "right" held 30 cycles.
    clear_log();
    apply(4'b1000, 1'b1, 30, t0);
    apply(4'b0000, 1'b1, 20, dummy);
`ifdef AUTOREPEAT_EN
    check("clean_count", 32'(pulse_cyc.size()), 32'd3);
    if (pulse_cyc.size() > 1) check("clean_rep_edge", 32'(pulse_cyc[1]), 32'(t0 + 28));
`else
    check("clean_count", 32'(pulse_cyc.size()), 32'd1);
`endif
    if (pulse_cyc.size() > 0) begin
      check("clean_edge", 32'(pulse_cyc[0]), 32'(t0 + 7));
      check("clean_val", 32'(pulse_val[0]), 32'h8);
    end

    // Bouncing "up": toggles every 2 cycles for 12 cycles, then held.
    clear_log();
    for (int k = 0; k < 6; k++) apply((k % 2 == 0) ? 4'b0001 : 4'b0000, 1'b1, 2, dummy);
    apply(4'b0001, 1'b1, 20, tl);
    apply(4'b0000, 1'b1, 20, dummy);
    check("bounce_count", 32'(pulse_cyc.size()), 32'd1);
    if (pulse_cyc.size() > 0) begin
      check("bounce_edge", 32'(pulse_cyc[0]), 32'(tl + 7));
      check("bounce_val", 32'(pulse_val[0]), 32'h1);
    end

    // "left" held 60 cycles.
    clear_log();
    apply(4'b0100, 1'b1, 60, t0);
    apply(4'b0000, 1'b1, 20, dummy);
`ifdef AUTOREPEAT_EN
    check("hold_count", 32'(pulse_cyc.size()), 32'd9);
    if (pulse_cyc.size() == 9) begin
      check("hold_rep1", 32'(pulse_cyc[1]), 32'(t0 + 28));
      check("hold_rep2", 32'(pulse_cyc[2]), 32'(t0 + 33));
      check("hold_last", 32'(pulse_cyc[8]), 32'(t0 + 63));
    end
`else
    check("hold_count", 32'(pulse_cyc.size()), 32'd1);
`endif
    if (pulse_cyc.size() > 0) begin
      check("hold_edge", 32'(pulse_cyc[0]), 32'(t0 + 7));
      check("hold_val", 32'(pulse_val[0]), 32'h4);
    end
    check("hold_released_act", 32'(bus.bot_activo), 32'h0);

    // Chord up+down, release down only, release all, then press down.
    clear_log();
    apply(4'b0011, 1'b1, 15, dummy);
    apply(4'b0001, 1'b1, 15, dummy);
    apply(4'b0000, 1'b1, 15, dummy);
    check("chord_no_pulse", 32'(pulse_cyc.size()), 32'd0);
    apply(4'b0010, 1'b1, 15, tp);
    apply(4'b0000, 1'b1, 20, dummy);
    check("chord_count", 32'(pulse_cyc.size()), 32'd1);
    if (pulse_cyc.size() > 0) begin
      check("chord_edge", 32'(pulse_cyc[0]), 32'(tp + 7));
      check("chord_val", 32'(pulse_val[0]), 32'h2);
    end

    // Press while disabled, enable mid-hold, re-press, then reset mid-hold.
    clear_log();
    apply(4'b1000, 1'b0, 10, dummy);
    apply(4'b1000, 1'b1, 10, dummy);
    apply(4'b0000, 1'b1, 15, dummy);
    check("disabled_no_pulse", 32'(pulse_cyc.size()), 32'd0);
    apply(4'b1000, 1'b1, 12, tp);
    @(negedge reloj);
    resetM = 1'b1;
    @(negedge reloj);
    check("midreset_out", 32'(bus.OUT_bot_fecha), 32'h0);
    check("midreset_act", 32'(bus.bot_activo), 32'h0);
    @(negedge reloj);
    resetM = 1'b0;
    tr = cyc + 1;
    repeat (14) @(negedge reloj);
    apply(4'b0000, 1'b1, 20, dummy);
    check("disable_count", 32'(pulse_cyc.size()), 32'd2);
    if (pulse_cyc.size() == 2) begin
      check("repress_edge", 32'(pulse_cyc[0]), 32'(tp + 7));
      check("post_reset_edge", 32'(pulse_cyc[1]), 32'(tr + 7));
      check("post_reset_val", 32'(pulse_val[1]), 32'h8);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
